// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes,
// datapath select encodings and the main FSM state type.
package multicycle_controller_pkg;

  // Opcodes of the supported instruction classes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // ALUOp as consumed by alu_decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Writeback / PC result source
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  // ALU operand B
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Immediate format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Main FSM states; encodings 11..15 are unreachable
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the main FSM (master) and the multicycle datapath (slave).
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       illegal_instr;
  logic       instr_done;

  modport master (
    input  op, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, reg_write, alu_op, imm_src, illegal_instr, instr_done
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, reg_write, alu_op, imm_src, illegal_instr, instr_done
  );

endinterface

// File: rtl/multicycle_controller_imm.sv
// Immediate-format decoder: purely a function of the opcode, independent of FSM state.
module imm_src_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  // Select the immediate layout for the opcode
  always_comb begin
    unique case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BR:   imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core. Only the state is registered;
// the control outputs are decoded from the state (plus mem_ready/zero for
// the PC/IR strobes) and the write strobes are gated off while in reset.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
)(
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_controller_if.master       bus
);

  state_e state_q;
  state_e state_d;
  logic   rdy;

  logic       pc_write_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic       reg_write_s;
  logic [1:0] alu_op_s;
  logic       illegal_s;
  logic       done_s;

  // Branch sense comes from funct3[0] alone; the upper bits are don't-care
  logic unused_funct3;
  assign unused_funct3 = ^bus.funct3[2:1];

  // With memory waiting disabled every access completes in one cycle
  assign rdy = bus.mem_ready | !MEM_WAIT_EN;

  // Next-state selection
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with asynchronous return to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Moore decode of datapath controls from the current state
  always_comb begin
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RS2;
    reg_write_s  = 1'b0;
    alu_op_s     = ALUOP_ADD;
    illegal_s    = 1'b0;
    done_s       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALURESULT;
        ir_write_s   = rdy;
        pc_write_s   = rdy;
      end
      S_DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        unique case (bus.op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR: illegal_s = 1'b0;
          default:                                illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
      end
      S_MEMREAD: adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = RES_READDATA;
        reg_write_s  = 1'b1;
        done_s       = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        done_s      = rdy;
      end
      S_EXECR: begin
        alu_src_a_s = SRCA_RS1;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_FOUR;
        pc_write_s  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s = SRCA_RS1;
        alu_op_s    = ALUOP_SUB;
        pc_write_s  = bus.zero ^ bus.funct3[0];
        done_s      = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are suppressed the moment reset is asserted
  assign bus.pc_write      = pc_write_s  & rst_n;
  assign bus.ir_write      = ir_write_s  & rst_n;
  assign bus.mem_write     = mem_write_s & rst_n;
  assign bus.reg_write     = reg_write_s & rst_n;
  assign bus.adr_src       = adr_src_s;
  assign bus.result_src    = result_src_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.illegal_instr = illegal_s;
  assign bus.instr_done    = done_s;

  imm_src_decoder u_imm_src_decoder (
    .op_i      (bus.op),
    .imm_src_o (bus.imm_src)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instance with memory waiting,
// one with mem_ready ignored. Inputs change on the falling edge; outputs are
// compared 1 ns later against hand-derived control vectors.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
  //  reg_write, alu_op, illegal_instr, instr_done}
  localparam logic [14:0] V_FETCH_RDY  = 15'b1_0_0_1_10_00_10_0_00_0_0;
  localparam logic [14:0] V_FETCH_WAIT = 15'b0_0_0_0_10_00_10_0_00_0_0;
  localparam logic [14:0] V_DECODE     = 15'b0_0_0_0_00_01_01_0_00_0_0;
  localparam logic [14:0] V_DECODE_ILL = 15'b0_0_0_0_00_01_01_0_00_1_0;
  localparam logic [14:0] V_MEMADR     = 15'b0_0_0_0_00_10_01_0_00_0_0;
  localparam logic [14:0] V_MEMREAD    = 15'b0_1_0_0_00_00_00_0_00_0_0;
  localparam logic [14:0] V_MEMWB      = 15'b0_0_0_0_01_00_00_1_00_0_1;
  localparam logic [14:0] V_MEMWR_WAIT = 15'b0_1_1_0_00_00_00_0_00_0_0;
  localparam logic [14:0] V_MEMWR_RDY  = 15'b0_1_1_0_00_00_00_0_00_0_1;
  localparam logic [14:0] V_EXECR      = 15'b0_0_0_0_00_10_00_0_10_0_0;
  localparam logic [14:0] V_EXECI      = 15'b0_0_0_0_00_10_01_0_10_0_0;
  localparam logic [14:0] V_ALUWB      = 15'b0_0_0_0_00_00_00_1_00_0_1;
  localparam logic [14:0] V_JAL        = 15'b1_0_0_0_00_01_10_0_00_0_0;
  localparam logic [14:0] V_BR_TAKEN   = 15'b1_0_0_0_00_10_00_0_01_0_1;
  localparam logic [14:0] V_BR_NOT     = 15'b0_0_0_0_00_10_00_0_01_0_1;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller_if if1 ();
  multicycle_controller_if if0 ();

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  multicycle_controller #(.MEM_WAIT_EN(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  logic [14:0] v1;
  logic [14:0] v0;
  assign v1 = {if1.pc_write, if1.adr_src, if1.mem_write, if1.ir_write, if1.result_src,
               if1.alu_src_a, if1.alu_src_b, if1.reg_write, if1.alu_op,
               if1.illegal_instr, if1.instr_done};
  assign v0 = {if0.pc_write, if0.adr_src, if0.mem_write, if0.ir_write, if0.result_src,
               if0.alu_src_a, if0.alu_src_b, if0.reg_write, if0.alu_op,
               if0.illegal_instr, if0.instr_done};

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic mr, input logic z);
    if1.op = op; if1.funct3 = f3; if1.mem_ready = mr; if1.zero = z;
    if0.op = op; if0.funct3 = f3; if0.mem_ready = mr; if0.zero = z;
  endtask

  // One clock: release reset if held, apply inputs, then compare the selected instance
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic mr, input logic z,
                      input bit use0, input logic [14:0] ev, input logic [1:0] ei,
                      input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    drive(op, f3, mr, z);
    #1;
    if (use0) begin
      check(tag, v0, ev);
      check({tag, "_imm"}, {13'b0, if0.imm_src}, {13'b0, ei});
    end else begin
      check(tag, v1, ev);
      check({tag, "_imm"}, {13'b0, if1.imm_src}, {13'b0, ei});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(OP_BAD, 3'b000, 1'b1, 1'b0);
    #1;
    // In reset with mem_ready high: FETCH selects but no strobes
    check("reset_w1", v1, V_FETCH_WAIT);
    check("reset_w0", v0, V_FETCH_WAIT);
    repeat (2) @(posedge clk);

    // add x3,x1,x2
    step(OP_R, 3'b000, 1'b1, 1'b0, 0, V_FETCH_RDY, 2'b00, "add_fetch");
    step(OP_R, 3'b000, 1'b1, 1'b0, 0, V_DECODE,    2'b00, "add_decode");
    step(OP_R, 3'b000, 1'b1, 1'b0, 0, V_EXECR,     2'b00, "add_execr");
    step(OP_R, 3'b000, 1'b1, 1'b0, 0, V_ALUWB,     2'b00, "add_aluwb");

    // addi
    step(OP_I, 3'b000, 1'b1, 1'b0, 0, V_FETCH_RDY, 2'b00, "addi_fetch");
    step(OP_I, 3'b000, 1'b1, 1'b0, 0, V_DECODE,    2'b00, "addi_decode");
    step(OP_I, 3'b000, 1'b1, 1'b0, 0, V_EXECI,     2'b00, "addi_execi");
    step(OP_I, 3'b000, 1'b1, 1'b0, 0, V_ALUWB,     2'b00, "addi_aluwb");

    // lw with 3 wait cycles in FETCH and 2 in MEMREAD: 10 cycles total
    step(OP_LW, 3'b010, 1'b0, 1'b0, 0, V_FETCH_WAIT, 2'b00, "lw_fetch_w1");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 0, V_FETCH_WAIT, 2'b00, "lw_fetch_w2");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 0, V_FETCH_WAIT, 2'b00, "lw_fetch_w3");
    step(OP_LW, 3'b010, 1'b1, 1'b0, 0, V_FETCH_RDY,  2'b00, "lw_fetch_rdy");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 0, V_DECODE,     2'b00, "lw_decode");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 0, V_MEMADR,     2'b00, "lw_memadr");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 0, V_MEMREAD,    2'b00, "lw_memread_w1");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 0, V_MEMREAD,    2'b00, "lw_memread_w2");
    step(OP_LW, 3'b010, 1'b1, 1'b0, 0, V_MEMREAD,    2'b00, "lw_memread_rdy");
    step(OP_LW, 3'b010, 1'b1, 1'b0, 0, V_MEMWB,      2'b00, "lw_memwb");

    // sw with one wait cycle in MEMWRITE
    step(OP_SW, 3'b010, 1'b1, 1'b0, 0, V_FETCH_RDY,  2'b01, "sw_fetch");
    step(OP_SW, 3'b010, 1'b1, 1'b0, 0, V_DECODE,     2'b01, "sw_decode");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 0, V_MEMADR,     2'b01, "sw_memadr");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 0, V_MEMWR_WAIT, 2'b01, "sw_memwr_wait");
    step(OP_SW, 3'b010, 1'b1, 1'b0, 0, V_MEMWR_RDY,  2'b01, "sw_memwr_rdy");

    // beq taken, bne not taken, odd funct3 decoded by bit 0
    step(OP_BR, 3'b000, 1'b1, 1'b1, 0, V_FETCH_RDY, 2'b10, "beq_fetch");
    step(OP_BR, 3'b000, 1'b1, 1'b1, 0, V_DECODE,    2'b10, "beq_decode");
    step(OP_BR, 3'b000, 1'b1, 1'b1, 0, V_BR_TAKEN,  2'b10, "beq_z1_branch");
    step(OP_BR, 3'b001, 1'b1, 1'b1, 0, V_FETCH_RDY, 2'b10, "bne_fetch");
    step(OP_BR, 3'b001, 1'b1, 1'b1, 0, V_DECODE,    2'b10, "bne_decode");
    step(OP_BR, 3'b001, 1'b1, 1'b1, 0, V_BR_NOT,    2'b10, "bne_z1_branch");
    step(OP_BR, 3'b000, 1'b1, 1'b0, 0, V_FETCH_RDY, 2'b10, "beq0_fetch");
    step(OP_BR, 3'b000, 1'b1, 1'b0, 0, V_DECODE,    2'b10, "beq0_decode");
    step(OP_BR, 3'b000, 1'b1, 1'b0, 0, V_BR_NOT,    2'b10, "beq_z0_branch");
    step(OP_BR, 3'b101, 1'b1, 1'b0, 0, V_FETCH_RDY, 2'b10, "f101_fetch");
    step(OP_BR, 3'b101, 1'b1, 1'b0, 0, V_DECODE,    2'b10, "f101_decode");
    step(OP_BR, 3'b101, 1'b1, 1'b0, 0, V_BR_TAKEN,  2'b10, "f101_z0_branch");

    // jal
    step(OP_JAL, 3'b000, 1'b1, 1'b0, 0, V_FETCH_RDY, 2'b11, "jal_fetch");
    step(OP_JAL, 3'b000, 1'b1, 1'b0, 0, V_DECODE,    2'b11, "jal_decode");
    step(OP_JAL, 3'b000, 1'b1, 1'b0, 0, V_JAL,       2'b11, "jal_jal");
    step(OP_JAL, 3'b000, 1'b1, 1'b0, 0, V_ALUWB,     2'b11, "jal_aluwb");

    // unsupported opcode returns to FETCH after a single DECODE pulse
    step(OP_BAD, 3'b000, 1'b1, 1'b0, 0, V_FETCH_RDY,  2'b00, "ill_fetch");
    step(OP_BAD, 3'b000, 1'b1, 1'b0, 0, V_DECODE_ILL, 2'b00, "ill_decode");
    step(OP_R,   3'b000, 1'b0, 1'b0, 0, V_FETCH_WAIT, 2'b00, "ill_back_fetch");
    step(OP_R,   3'b000, 1'b1, 1'b0, 0, V_FETCH_RDY,  2'b00, "ill_next_fetch");
    step(OP_R,   3'b000, 1'b1, 1'b0, 0, V_DECODE,     2'b00, "ill_next_decode");
    step(OP_R,   3'b000, 1'b1, 1'b0, 0, V_EXECR,      2'b00, "ill_next_execr");
    step(OP_R,   3'b000, 1'b1, 1'b0, 0, V_ALUWB,      2'b00, "ill_next_aluwb");

    // reset asserted while sw is stalled in MEMWRITE
    step(OP_SW, 3'b010, 1'b1, 1'b0, 0, V_FETCH_RDY,  2'b01, "rsw_fetch");
    step(OP_SW, 3'b010, 1'b1, 1'b0, 0, V_DECODE,     2'b01, "rsw_decode");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 0, V_MEMADR,     2'b01, "rsw_memadr");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 0, V_MEMWR_WAIT, 2'b01, "rsw_memwr_wait");
    #2;
    if1.mem_ready = 1'b1;
    if0.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_w1", v1, V_FETCH_WAIT);
    check("rst_mid_w0", v0, V_FETCH_WAIT);
    @(posedge clk);

    // MEM_WAIT_EN=0 instance runs lw and sw with mem_ready held low
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1, V_FETCH_RDY, 2'b00, "nw_lw_fetch");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1, V_DECODE,    2'b00, "nw_lw_decode");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1, V_MEMADR,    2'b00, "nw_lw_memadr");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1, V_MEMREAD,   2'b00, "nw_lw_memread");
    step(OP_LW, 3'b010, 1'b0, 1'b0, 1, V_MEMWB,     2'b00, "nw_lw_memwb");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 1, V_FETCH_RDY, 2'b01, "nw_sw_fetch");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 1, V_DECODE,    2'b01, "nw_sw_decode");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 1, V_MEMADR,    2'b01, "nw_sw_memadr");
    step(OP_SW, 3'b010, 1'b0, 1'b0, 1, V_MEMWR_RDY, 2'b01, "nw_sw_memwr");
    step(OP_R,  3'b000, 1'b0, 1'b0, 1, V_FETCH_RDY, 2'b00, "nw_back_fetch");
    // the waiting instance has stayed in FETCH throughout with mem_ready low
    check("w1_held_fetch", v1, V_FETCH_WAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
